// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: reads a 16-bit little-endian instruction word from
// byte-wide memory at the current PC in two byte reads. It pulses PCInc once
// per byte so the upstream register file steps the PC, and it assembles the
// two bytes into IR for the control unit.
module instruction_fetch_unit #(
   parameter logic [15:0] IR_RESET = 16'h0000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] Address,
   input  logic [7:0]  MemData,
   output logic        MemRead,
   output logic [15:0] MemAddr,
   output logic        PCInc,
   output logic [15:0] IR,
   output logic        Busy,
   output logic        Done
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_LO  = 3'd1,
      CAP_LO = 3'd2,
      CAP_HI = 3'd3,
      DONE   = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   ir_q, ir_d;
   logic                mem_read_q, mem_read_d;
   logic                pc_inc_q, pc_inc_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // Next-state sequencing and byte capture into the instruction register
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         IDLE: begin
            if (Start) state_d = RD_LO;
         end
         RD_LO: begin
            state_d = CAP_LO;
         end
         CAP_LO: begin
            ir_d[BYTE_W-1:0] = MemData;
            state_d          = CAP_HI;
         end
         CAP_HI: begin
            ir_d[WORD_W-1:BYTE_W] = MemData;
            state_d               = DONE;
         end
         DONE: begin
            state_d = Start ? RD_LO : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Strobes decoded from the upcoming state so the flopped copies line up with it
   always_comb begin
      mem_read_d = 1'b0;
      pc_inc_d   = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      case (state_d)
         RD_LO, CAP_LO: begin
            mem_read_d = 1'b1;
            pc_inc_d   = 1'b1;
            busy_d     = 1'b1;
         end
         CAP_HI: begin
            busy_d = 1'b1;
         end
         DONE: begin
            done_d = 1'b1;
         end
         default: begin
            mem_read_d = 1'b0;
         end
      endcase
   end

   // State, instruction register and output strobes with synchronous reset
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q    <= IDLE;
         ir_q       <= IR_RESET;
         mem_read_q <= 1'b0;
         pc_inc_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         mem_read_q <= mem_read_d;
         pc_inc_q   <= pc_inc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // The PC already reflects the previous increment, so the address passes straight through
   assign MemAddr = mem_read_q ? Address : 16'h0000;
   assign MemRead = mem_read_q;
   assign PCInc   = pc_inc_q;
   assign IR      = ir_q;
   assign Busy    = busy_q;
   assign Done    = done_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a byte memory and a PC register model
// surround the DUT; expected words come from the memory image at the PC.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic [15:0] Address;
   logic [7:0]  MemData;
   logic        MemRead;
   logic [15:0] MemAddr;
   logic        PCInc;
   logic [15:0] IR;
   logic        Busy;
   logic        Done;

   logic [7:0]  mem [0:65535];
   logic [15:0] pc = 16'h0100;
   logic        pc_ld = 1'b0;
   logic [15:0] pc_ld_val = 16'h0000;
   int          pcinc_cnt = 0;
   logic [7:0]  mem_data_q = 8'h00;

   int n_cmp = 0;
   int n_err = 0;

   instruction_fetch_unit #(.IR_RESET(16'h0000)) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Start  (Start),
      .Address(Address),
      .MemData(MemData),
      .MemRead(MemRead),
      .MemAddr(MemAddr),
      .PCInc  (PCInc),
      .IR     (IR),
      .Busy   (Busy),
      .Done   (Done)
   );

   always #5 Clock = ~Clock;

   // Address register file model: PC register stepping on each PCInc
   always @(posedge Clock) begin
      if (pc_ld) pc <= pc_ld_val;
      else if (PCInc === 1'b1) begin
         pc        <= pc + 16'd1;
         pcinc_cnt <= pcinc_cnt + 1;
      end
   end
   assign Address = pc;

   // Byte memory with one cycle read latency; garbage when not read
   always @(posedge Clock) begin
      if (MemRead === 1'b1) mem_data_q <= mem[MemAddr];
      else                  mem_data_q <= 8'($urandom);
   end
   assign MemData = mem_data_q;

   // Expected {Busy, MemRead, PCInc, Done} for cycle c (1..4) after Start is sampled
   function automatic logic [3:0] exp_strobes(input int c);
      case (c)
         1, 2:    return 4'b1110;
         3:       return 4'b1000;
         4:       return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   // Little-endian word stored at address a, with 16-bit address wrap
   function automatic logic [15:0] word_at(input logic [15:0] a);
      logic [15:0] a1;
      a1 = a + 16'd1;
      return {mem[a1], mem[a]};
   endfunction

   task automatic set_pc(input logic [15:0] v);
      pc_ld_val = v;
      pc_ld     = 1'b1;
      @(negedge Clock);
      pc_ld     = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] n;
      Reset = 1'b0;
      Start = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge Clock);
         n_cmp++;
         if ({Busy, MemRead, PCInc, Done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_strobes: got %b want 0000", {Busy, MemRead, PCInc, Done});
         end
         n_cmp++;
         if (MemAddr !== 16'h0000 || IR !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_ir_addr: got IR=%h MemAddr=%h want 0000/0000", IR, MemAddr);
         end
      end
      n = pc;
      Reset = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge Clock);
         if (c == 1) begin
            Start = 1'b0;
            n_cmp++;
            if ({Busy, MemRead, PCInc, Done} !== exp_strobes(1)) begin
               n_err++;
               $display("FAIL reset_release_start: got %b want %b", {Busy, MemRead, PCInc, Done}, exp_strobes(1));
            end
         end
      end
      n_cmp++;
      if (Done !== 1'b1 || IR !== word_at(n)) begin
         n_err++;
         $display("FAIL reset_release_word: got Done=%b IR=%h want 1/%h", Done, IR, word_at(n));
      end
   endtask

   task automatic test_single_fetch();
      logic [15:0] n;
      int base;
      set_pc(16'h0010);
      mem[16'h0010] = 8'h34;
      mem[16'h0011] = 8'h12;
      n = pc;
      base = pcinc_cnt;
      Start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge Clock);
         if (c == 1) Start = 1'b0;
         n_cmp++;
         if ({Busy, MemRead, PCInc, Done} !== exp_strobes(c)) begin
            n_err++;
            $display("FAIL single_strobes cyc%0d: got %b want %b", c, {Busy, MemRead, PCInc, Done}, exp_strobes(c));
         end
         n_cmp++;
         if (MemAddr !== ((c == 1) ? n : (c == 2) ? n + 16'd1 : 16'h0000)) begin
            n_err++;
            $display("FAIL single_memaddr cyc%0d: got %h", c, MemAddr);
         end
         if (c == 3) begin
            n_cmp++;
            if (IR[7:0] !== mem[n]) begin
               n_err++;
               $display("FAIL single_lo_byte: got %h want %h", IR[7:0], mem[n]);
            end
         end
      end
      n_cmp++;
      if (IR !== 16'h1234 || IR !== word_at(n)) begin
         n_err++;
         $display("FAIL single_ir: got %h want 1234", IR);
      end
      n_cmp++;
      if (pc !== 16'h0012 || pcinc_cnt - base != 2) begin
         n_err++;
         $display("FAIL single_pc: got pc=%h pulses=%0d want 0012/2", pc, pcinc_cnt - base);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] n;
      int base;
      int c;
      set_pc(16'h0020);
      mem[16'h0020] = 8'hEF;
      mem[16'h0021] = 8'hBE;
      mem[16'h0022] = 8'hFE;
      mem[16'h0023] = 8'hCA;
      n = pc;
      base = pcinc_cnt;
      Start = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge Clock);
         c = ((i - 1) % 4) + 1;
         if (i == 8) Start = 1'b0;
         n_cmp++;
         if ({Busy, MemRead, PCInc, Done} !== exp_strobes(c)) begin
            n_err++;
            $display("FAIL b2b_strobes cyc%0d: got %b want %b", i, {Busy, MemRead, PCInc, Done}, exp_strobes(c));
         end
         if (c == 4) begin
            n_cmp++;
            if (IR !== ((i == 4) ? 16'hBEEF : 16'hCAFE)) begin
               n_err++;
               $display("FAIL b2b_ir cyc%0d: got %h want %h", i, IR, (i == 4) ? 16'hBEEF : 16'hCAFE);
            end
         end
      end
      n_cmp++;
      if (pc !== 16'h0024 || pcinc_cnt - base != 4) begin
         n_err++;
         $display("FAIL b2b_pc: got pc=%h pulses=%0d want 0024/4", pc, pcinc_cnt - base);
      end
      @(negedge Clock);
      n_cmp++;
      if ({Busy, MemRead, PCInc, Done} !== 4'b0000) begin
         n_err++;
         $display("FAIL b2b_idle: got %b want 0000", {Busy, MemRead, PCInc, Done});
      end
   endtask

   task automatic test_wrap();
      set_pc(16'hFFFF);
      mem[16'hFFFF] = 8'hAA;
      mem[16'h0000] = 8'h55;
      Start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge Clock);
         if (c == 1) Start = 1'b0;
         if (c == 2) begin
            n_cmp++;
            if (MemAddr !== 16'h0000 || MemRead !== 1'b1) begin
               n_err++;
               $display("FAIL wrap_hi_addr: got %h rd=%b want 0000/1", MemAddr, MemRead);
            end
         end
      end
      n_cmp++;
      if (Done !== 1'b1 || IR !== 16'h55AA || pc !== 16'h0001) begin
         n_err++;
         $display("FAIL wrap_word: got Done=%b IR=%h pc=%h want 1/55AA/0001", Done, IR, pc);
      end
   endtask

   task automatic test_start_busy();
      logic [15:0] n;
      int base;
      int dones;
      set_pc(16'($urandom));
      n = pc;
      base = pcinc_cnt;
      dones = 0;
      Start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge Clock);
         if (Done === 1'b1) dones++;
         if (c == 1) Start = 1'b0;
         if (c == 2) Start = 1'b1;
         if (c == 3) Start = 1'b0;
         if (c == 4) begin
            n_cmp++;
            if (IR !== word_at(n)) begin
               n_err++;
               $display("FAIL busy_ir: got %h want %h", IR, word_at(n));
            end
         end
      end
      n_cmp++;
      if (dones != 1 || pcinc_cnt - base != 2) begin
         n_err++;
         $display("FAIL busy_ignore: got dones=%0d pulses=%0d want 1/2", dones, pcinc_cnt - base);
      end
      n_cmp++;
      if ({Busy, MemRead, PCInc, Done} !== 4'b0000) begin
         n_err++;
         $display("FAIL busy_idle: got %b want 0000", {Busy, MemRead, PCInc, Done});
      end
   endtask

   // stage 1 resets during RD_LO, stage 2 during CAP_LO; each PCInc already
   // on the wire at the reset edge still reaches the register file
   task automatic test_reset_mid(input int stage);
      logic [15:0] n;
      logic [15:0] m;
      int dones;
      set_pc(16'($urandom));
      n = pc;
      Start = 1'b1;
      for (int c = 1; c <= stage; c++) begin
         @(negedge Clock);
         if (c == 1) Start = 1'b0;
      end
      Reset = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
      n_cmp++;
      if ({Busy, MemRead, PCInc, Done} !== 4'b0000 || IR !== 16'h0000) begin
         n_err++;
         $display("FAIL midrst%0d_state: got %b IR=%h want 0000/0000", stage, {Busy, MemRead, PCInc, Done}, IR);
      end
      n_cmp++;
      if (pc !== n + 16'(stage)) begin
         n_err++;
         $display("FAIL midrst%0d_pc: got %h want %h", stage, pc, n + 16'(stage));
      end
      dones = 0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge Clock);
         if (Done === 1'b1) dones++;
      end
      n_cmp++;
      if (dones != 0) begin
         n_err++;
         $display("FAIL midrst%0d_nodone: got %0d want 0", stage, dones);
      end
      m = pc;
      Start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge Clock);
         if (c == 1) Start = 1'b0;
      end
      n_cmp++;
      if (Done !== 1'b1 || IR !== word_at(m)) begin
         n_err++;
         $display("FAIL midrst%0d_refetch: got Done=%b IR=%h want 1/%h", stage, Done, IR, word_at(m));
      end
   endtask

   task automatic test_random();
      logic [15:0] n;
      int k;
      int base;
      for (int it = 0; it < 20; it++) begin
         set_pc(16'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge Clock);
         k = int'($urandom_range(1, 3));
         n = pc;
         base = pcinc_cnt;
         Start = 1'b1;
         for (int f = 0; f < k; f++) begin
            for (int c = 1; c <= 4; c++) begin
               @(negedge Clock);
               if (c == 4 && f == k - 1) Start = 1'b0;
            end
            n_cmp++;
            if (Done !== 1'b1 || IR !== word_at(n + 16'(2 * f))) begin
               n_err++;
               $display("FAIL rand%0d_word%0d: got Done=%b IR=%h want 1/%h", it, f, Done, IR, word_at(n + 16'(2 * f)));
            end
         end
         n_cmp++;
         if (pc !== n + 16'(2 * k) || pcinc_cnt - base != 2 * k) begin
            n_err++;
            $display("FAIL rand%0d_pc: got pc=%h pulses=%0d want %h/%0d", it, pc, pcinc_cnt - base, n + 16'(2 * k), 2 * k);
         end
         @(negedge Clock);
      end
   endtask

   initial begin
      Reset = 1'b0;
      Start = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_wrap();
      test_start_busy();
      test_reset_mid(1);
      test_reset_mid(2);
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
